// File: rtl/quad_encoder_emulator.sv
// ============================================================================
// quad_encoder_emulator
//
// Purpose:
//   Drives quadrature A/B (and optionally an index pulse Z) so that an
//   emulated shaft position walks from its current value to a commanded
//   target, one count per edge, with a programmable number of clocks
//   between edges. Intended to feed a quadrature decoder for closed-loop
//   bench / hardware-in-the-loop testing.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous, active-high reset
//   i_load      one-cycle strobe; captures i_target and i_period
//   i_target    signed target position (counts)
//   i_period    clocks between successive A/B edges (0 behaves as 1)
//   i_enable    1 = motion allowed, 0 = freeze divider/phase/position
//   o_A, o_B    registered quadrature channels (A leads B going forward)
//   o_Z         registered index pulse (constant 0 unless index enabled)
//   o_position  current emulated position, signed
//   o_dir       1 = last step was +1, 0 = last step was -1
//   o_busy      high while moving
//   o_done      one-cycle pulse when the target is reached
//
// Configuration:
//   `define QUAD_ENCODER_EMULATOR_INDEX_EN to build the revolution counter
//   (0..COUNTS_PER_REV-1, wrapping both ways) and drive o_Z high while it
//   is 0. Without it the counter is absent and o_Z is tied low.
// ============================================================================
module quad_encoder_emulator #(
    parameter int POS_WIDTH      = 13,
    parameter int DIV_WIDTH      = 16,
    parameter int COUNTS_PER_REV = 1496
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [POS_WIDTH-1:0] i_target,
    input  logic [DIV_WIDTH-1:0] i_period,
    input  logic                 i_enable,
    output logic                 o_A,
    output logic                 o_B,
    output logic                 o_Z,
    output logic [POS_WIDTH-1:0] o_position,
    output logic                 o_dir,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [POS_WIDTH-1:0] target_q, target_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic [1:0]           phase_q, phase_d;   // {A, B}, Gray-coded
    logic                 dir_q, dir_d;

    logic [DIV_WIDTH-1:0] period_eff;
    logic [POS_WIDTH-1:0] tgt_eff;
    logic                 at_target;
    logic                 fwd;
    logic                 step;

    // ------------------------------------------------------------------
    // Shared decode. A load in RUN retargets immediately, so the target
    // used for this cycle's decisions is the incoming one when i_load is
    // high.
    // ------------------------------------------------------------------
    always_comb begin
        period_eff = (i_period == '0) ? DIV_WIDTH'(1) : i_period;
        tgt_eff    = i_load ? i_target : target_q;
        at_target  = (tgt_eff == pos_q);
        fwd        = ($signed(tgt_eff) > $signed(pos_q));
        step       = (state_q == S_RUN) && i_enable && !at_target && (div_q == '0);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create order-dependent
    // simulation that no longer matches the synthesized flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // at the top; a path that leaves one unassigned infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_load) begin
                    state_d = at_target ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (at_target) begin
                    state_d = S_DONE;
                end else if (step && (pos_d == tgt_eff)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from the state register, so glitch-free)
    // ------------------------------------------------------------------
    always_comb begin
        o_busy = (state_q == S_RUN);
        o_done = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        target_d = i_load ? i_target : target_q;
        period_d = i_load ? period_eff : period_q;
        div_d    = div_q;
        pos_d    = pos_q;
        phase_d  = phase_q;
        dir_d    = dir_q;

        if (state_q != S_RUN) begin
            if (i_load && !at_target) begin
                div_d = period_eff - DIV_WIDTH'(1);
            end
        end else if (i_enable && !at_target) begin
            if (div_q == '0) begin
                // Reload uses the period in force before any same-cycle
                // load; a new period takes effect from the following reload.
                div_d = period_q - DIV_WIDTH'(1);
                dir_d = fwd;
                if (fwd) begin
                    pos_d   = pos_q + POS_WIDTH'(1);
                    // 00 -> 10 -> 11 -> 01 -> 00
                    phase_d = {~phase_q[0], phase_q[1]};
                end else begin
                    pos_d   = pos_q - POS_WIDTH'(1);
                    // 00 -> 01 -> 11 -> 10 -> 00
                    phase_d = {phase_q[0], ~phase_q[1]};
                end
            end else begin
                div_d = div_q - DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            target_q <= '0;
            period_q <= DIV_WIDTH'(1);
            div_q    <= '0;
            pos_q    <= '0;
            phase_q  <= 2'b00;
            dir_q    <= 1'b1;
        end else begin
            target_q <= target_d;
            period_q <= period_d;
            div_q    <= div_d;
            pos_q    <= pos_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
        end
    end

    assign o_A        = phase_q[1];
    assign o_B        = phase_q[0];
    assign o_position = pos_q;
    assign o_dir      = dir_q;

    // ------------------------------------------------------------------
    // Optional index: revolution counter follows every step and Z is
    // registered alongside it so it changes on the same edge as A/B.
    // ------------------------------------------------------------------
`ifdef QUAD_ENCODER_EMULATOR_INDEX_EN
    localparam int REV_W = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(COUNTS_PER_REV - 1);

    logic [REV_W-1:0] rev_q, rev_d;
    logic             z_q, z_d;

    always_comb begin
        rev_d = rev_q;
        if (step) begin
            if (fwd) begin
                rev_d = (rev_q == REV_MAX) ? '0 : rev_q + REV_W'(1);
            end else begin
                rev_d = (rev_q == '0) ? REV_MAX : rev_q - REV_W'(1);
            end
        end
        z_d = (rev_d == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rev_q <= '0;
            z_q   <= 1'b1;
        end else begin
            rev_q <= rev_d;
            z_q   <= z_d;
        end
    end

    assign o_Z = z_q;
`else
    assign o_Z = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// ============================================================================
// tb_quad_encoder_emulator
//
// Self-checking bench. The reference model describes each move in terms of
// counts: position = start + dir * floor(enabled_clocks / P), capped at the
// distance; A/B follow from position mod 4 and Z from position mod CPR.
// ============================================================================
module tb_quad_encoder_emulator;

    localparam int PW  = 13;
    localparam int DW  = 16;
    localparam int CPR = 8;
    localparam int EDGE_LIMIT = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [PW-1:0] target;
    logic [DW-1:0] period;
    logic          enable;
    logic          a_o, b_o, z_o, dir_o, busy_o, done_o;
    logic [PW-1:0] pos_o;

    int  checks   = 0;
    int  failures = 0;
    int  m_pos    = 0;
    bit  m_dir    = 1'b1;

    quad_encoder_emulator #(
        .POS_WIDTH      (PW),
        .DIV_WIDTH      (DW),
        .COUNTS_PER_REV (CPR)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (load),
        .i_target   (target),
        .i_period   (period),
        .i_enable   (enable),
        .o_A        (a_o),
        .o_B        (b_o),
        .o_Z        (z_o),
        .o_position (pos_o),
        .o_dir      (dir_o),
        .o_busy     (busy_o),
        .o_done     (done_o)
    );

    always #5 clk = ~clk;

    // Expected output vector {position, A, B, Z, dir, busy, done}.
    function automatic logic [PW+5:0] model_vec(int pos, bit dir, bit busy, bit done);
        int            g;
        logic          a, b, z;
        logic [PW-1:0] p;
        g = ((pos % 4) + 4) % 4;
        case (g)
            0:       begin a = 1'b0; b = 1'b0; end
            1:       begin a = 1'b1; b = 1'b0; end
            2:       begin a = 1'b1; b = 1'b1; end
            default: begin a = 1'b0; b = 1'b1; end
        endcase
`ifdef QUAD_ENCODER_EMULATOR_INDEX_EN
        z = ((((pos % CPR) + CPR) % CPR) == 0);
`else
        z = 1'b0;
`endif
        p = pos[PW-1:0];
        return {p, a, b, z, dir, busy, done};
    endfunction

    function automatic logic [PW+5:0] dut_vec();
        return {pos_o, a_o, b_o, z_o, dir_o, busy_o, done_o};
    endfunction

    // Leaves the bench just after a falling edge with inputs idle.
    task automatic do_reset();
        rst    = 1'b1;
        load   = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_pos = 0;
        m_dir = 1'b1;
    endtask

    // Generic move: freeze window [fs, fs+fl) on clock index, optional
    // random enable, optional chaining (next load lands in the DONE cycle).
    task automatic test_move(input string name, input int tgt, input int per,
                             input int fs, input int fl, input bit rand_en,
                             input bit chain);
        int  pos0, p, n, dsign, en_cnt, steps, t_fin, k, exp_pos, stop_k;
        bit  en, exp_busy, exp_done;
        logic [PW+5:0] exp_v, act_v;
        pos0   = m_pos;
        p      = (per == 0) ? 1 : per;
        n      = (tgt > pos0) ? tgt - pos0 : pos0 - tgt;
        dsign  = (tgt > pos0) ? 1 : -1;
        en_cnt = 0;
        steps  = 0;
        t_fin  = (n == 0) ? 0 : -1;

        load   = 1'b1;
        target = tgt[PW-1:0];
        period = per[DW-1:0];
        enable = !(0 >= fs && 0 < fs + fl);

        for (int t = 1; t <= EDGE_LIMIT + 2; t++) begin
            @(negedge clk);
            k        = t - 1;
            exp_pos  = pos0 + dsign * steps;
            exp_busy = (n > 0) && (steps < n);
            exp_done = (k == t_fin);
            exp_v    = model_vec(exp_pos, m_dir, exp_busy, exp_done);
            act_v    = dut_vec();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL %s clk=%0d got{pos,A,B,Z,dir,busy,done}=%h want=%h",
                         name, k, act_v, exp_v);
            end
            stop_k = chain ? t_fin : t_fin + 1;
            if (t_fin >= 0 && k == stop_k) break;
            if (t == EDGE_LIMIT + 2) begin
                checks++;
                failures++;
                $display("FAIL %s timeout: target %0d not reached in %0d clocks", name, tgt, EDGE_LIMIT);
                break;
            end
            en = !(t >= fs && t < fs + fl);
            if (rand_en && $urandom_range(0, 3) == 0) en = 1'b0;
            load   = 1'b0;
            enable = en;
            if (steps < n && en) begin
                en_cnt++;
                if (en_cnt % p == 0) begin
                    steps++;
                    m_dir = (dsign > 0);
                    if (steps == n) t_fin = t;
                end
            end
        end
        load   = 1'b0;
        enable = 1'b1;
        m_pos  = tgt;
    endtask

    task automatic test_reset();
        logic [PW+5:0] exp_v;
        do_reset();
        exp_v = model_vec(0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_v) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", dut_vec(), exp_v);
        end
        // Start a move to 50 and abort it with an asynchronous reset.
        load   = 1'b1;
        target = PW'(50);
        period = DW'(3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            load = 1'b0;
        end
        checks++;
        if (pos_o === '0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_premove got pos=%0d busy=%b want pos>0 busy=1", pos_o, busy_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== exp_v) begin
            failures++;
            $display("FAIL reset_async got=%h want=%h", dut_vec(), exp_v);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_v) begin
                failures++;
                $display("FAIL reset_hold clk=%0d got=%h want=%h", i, dut_vec(), exp_v);
            end
        end
        m_pos = 0;
        m_dir = 1'b1;
    endtask

    task automatic test_retarget();
        int  exp_pos, back, dones;
        bit  exp_dir, exp_busy, exp_done;
        logic [PW+5:0] exp_v;
        do_reset();
        dones  = 0;
        load   = 1'b1;
        target = PW'(100);
        period = DW'(5);
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            if (t - 1 < 105) begin
                exp_pos  = (t - 1) / 5;
                exp_dir  = 1'b1;
                exp_busy = 1'b1;
            end else begin
                back     = (t - 1 - 105) / 5 + 1;
                if (back > 10) back = 10;
                exp_pos  = 20 - back;
                exp_dir  = 1'b0;
                exp_busy = (back < 10);
            end
            exp_done = (t - 1 == 150);
            if (done_o === 1'b1) dones++;
            exp_v = model_vec(exp_pos, exp_dir, exp_busy, exp_done);
            checks++;
            if (dut_vec() !== exp_v) begin
                failures++;
                $display("FAIL retarget clk=%0d got=%h want=%h", t - 1, dut_vec(), exp_v);
            end
            if (t - 1 == 151) break;
            load   = (t == 102);
            target = PW'(10);
            period = DW'(5);
        end
        load = 1'b0;
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL retarget_done_count got=%0d want=1", dones);
        end
        m_pos = 10;
        m_dir = 1'b0;
    endtask

    task automatic test_random();
        int tgt, per;
        for (int i = 0; i < 10; i++) begin
            tgt = m_pos + int'($urandom_range(0, 24)) - 12;
            per = int'($urandom_range(0, 3));
            test_move("random", tgt, per, 0, 0, 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        target = '0;
        period = '0;
        enable = 1'b1;

        test_reset();

        do_reset();
        test_move("forward_p10", 4, 10, 0, 0, 1'b0, 1'b0);

        do_reset();
        test_move("reverse_p0", -3, 0, 0, 0, 1'b0, 1'b0);

        test_move("same_target", m_pos, 7, 0, 0, 1'b0, 1'b0);

        test_retarget();

        do_reset();
        test_move("freeze", 30, 4, 33, 50, 1'b0, 1'b0);

        test_move("load_disabled", m_pos + 5, 2, 0, 15, 1'b0, 1'b0);

        do_reset();
        test_move("index_fwd", 16, 1, 0, 0, 1'b0, 1'b0);
        test_move("index_rev", -1, 2, 0, 0, 1'b0, 1'b0);

        test_move("back_to_back_a", m_pos + 3, 1, 0, 0, 1'b0, 1'b1);
        test_move("back_to_back_b", m_pos - 2, 3, 0, 0, 1'b0, 1'b1);
        test_move("back_to_back_c", m_pos, 2, 0, 0, 1'b0, 1'b0);

        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
